// File: rtl/ccd_skew_cal_ctrl.sv
// Skew calibration sequencer for the ccd correlation detector.
// SAR search of the delay code, then optional bang-bang tracking.
module ccd_skew_cal_ctrl #(
    parameter int DLY_W    = 6,
    parameter int WIN_LOG2 = 10,
    parameter int SETTLE   = 8,
    parameter int LOCK_CNT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             track_en,
    input  logic             ccd_sign,
    output logic             ccd_clr,
    output logic [DLY_W-1:0] dly_code,
    output logic             busy,
    output logic             done,
    output logic             locked
);

    localparam int WIN  = 1 << WIN_LOG2;
    localparam int CMAX = (WIN > SETTLE) ? WIN : SETTLE;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int IW   = (DLY_W > 1) ? $clog2(DLY_W) : 1;
    localparam int LW   = $clog2(LOCK_CNT + 1);

    localparam logic [DLY_W-1:0] MID  = {1'b1, {(DLY_W-1){1'b0}}};
    localparam logic [DLY_W-1:0] ONES = '1;

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_SETTLE, S_ACCUM, S_SAMPLE, S_DONE
    } state_t;

    typedef enum logic {M_SAR, M_TRACK} mode_t;

    state_t           state, state_n;
    mode_t            mode, mode_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [IW-1:0]    idx, idx_n;
    logic [DLY_W-1:0] code_n;
    logic [LW-1:0]    rev, rev_n;
    logic             dir_up, dir_up_n;
    logic             has_prev, has_prev_n;
    logic             lock_n;
    logic             step_up, blocked, reversal;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            mode     <= M_SAR;
            cnt      <= '0;
            idx      <= '0;
            dly_code <= MID;
            rev      <= '0;
            dir_up   <= 1'b0;
            has_prev <= 1'b0;
            locked   <= 1'b0;
            ccd_clr  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            mode     <= mode_n;
            cnt      <= cnt_n;
            idx      <= idx_n;
            dly_code <= code_n;
            rev      <= rev_n;
            dir_up   <= dir_up_n;
            has_prev <= has_prev_n;
            locked   <= lock_n;
            ccd_clr  <= (state_n == S_CLEAR);
            busy     <= (state_n != S_IDLE) && (state_n != S_DONE);
            done     <= (state_n == S_DONE);
        end
    end

    // Tracking step: down when the delay is too large, blocked at the rails
    always_comb begin
        step_up  = !ccd_sign;
        blocked  = ccd_sign ? (dly_code == '0) : (dly_code == ONES);
        reversal = has_prev && (dir_up != step_up) && !blocked;
    end

    always_comb begin
        state_n    = state;
        mode_n     = mode;
        cnt_n      = cnt + 1'b1;
        idx_n      = idx;
        code_n     = dly_code;
        rev_n      = rev;
        dir_up_n   = dir_up;
        has_prev_n = has_prev;
        lock_n     = locked;
        unique case (state)
            S_IDLE: begin
                cnt_n = '0;
                if (start) begin
                    mode_n  = M_SAR;
                    idx_n   = IW'(DLY_W - 1);
                    code_n  = MID;
                    state_n = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (cnt == CW'(1)) begin
                    cnt_n   = '0;
                    state_n = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (cnt == CW'(SETTLE - 1)) begin
                    cnt_n   = '0;
                    state_n = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (cnt == CW'(WIN - 1)) begin
                    cnt_n   = '0;
                    state_n = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                cnt_n = '0;
                if (mode == M_SAR) begin
                    if (ccd_sign) code_n[idx] = 1'b0;
                    if (idx != '0) begin
                        code_n[idx-1'b1] = 1'b1;
                        idx_n            = idx - 1'b1;
                        state_n          = S_CLEAR;
                    end else if (track_en) begin
                        mode_n     = M_TRACK;
                        has_prev_n = 1'b0;
                        rev_n      = '0;
                        lock_n     = 1'b0;
                        state_n    = S_CLEAR;
                    end else begin
                        state_n = S_DONE;
                    end
                end else begin
                    if (!blocked)
                        code_n = step_up ? dly_code + 1'b1 : dly_code - 1'b1;
                    if (reversal)
                        rev_n = (rev == LW'(LOCK_CNT)) ? rev : rev + 1'b1;
                    else
                        rev_n = '0;
                    dir_up_n   = step_up;
                    has_prev_n = 1'b1;
                    lock_n     = (rev_n == LW'(LOCK_CNT));
                    if (track_en) begin
                        state_n = S_CLEAR;
                    end else begin
                        lock_n  = 1'b0;
                        state_n = S_IDLE;
                    end
                end
            end
            S_DONE: begin
                cnt_n   = '0;
                state_n = S_IDLE;
            end
            default: begin
                cnt_n   = '0;
                state_n = S_IDLE;
            end
        endcase
        if (abort) begin
            state_n = S_IDLE;
            cnt_n   = '0;
            code_n  = dly_code;
            lock_n  = 1'b0;
        end
    end

endmodule

// File: tb/tb_ccd_skew_cal_ctrl.sv
// Directed bench for ccd_skew_cal_ctrl with a threshold ccd model.
// Inputs driven and outputs sampled on the falling edge.
module tb_ccd_skew_cal_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       track_en = 1'b0;
    logic       ccd_sign;
    logic       ccd_clr;
    logic [3:0] dly_code;
    logic       busy;
    logic       done;
    logic       locked;

    logic [3:0] thr = 4'd9;
    logic       force0 = 1'b0;
    int         n_tests = 0;
    int         n_fail = 0;
    int         clr_cnt;

    assign ccd_sign = force0 ? 1'b0 : (dly_code > thr);

    always #5 clk = ~clk;

    ccd_skew_cal_ctrl #(
        .DLY_W(4), .WIN_LOG2(4), .SETTLE(2), .LOCK_CNT(4)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .track_en(track_en), .ccd_sign(ccd_sign), .ccd_clr(ccd_clr),
        .dly_code(dly_code), .busy(busy), .done(done), .locked(locked)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic start_pulse();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_sar(input logic [3:0] t, input logic [3:0] exp);
        thr = t;
        start_pulse();
        repeat (84) @(negedge clk);
        check("sar_done", done, 1);
        check("sar_code", dly_code, exp);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        // 1: reset
        repeat (3) @(negedge clk);
        check("rst_code", dly_code, 8);
        check("rst_busy", busy, 0);
        rst = 1'b1;
        @(negedge clk);
        check("rel_code", dly_code, 8);
        check("rel_busy", busy, 0);
        check("rel_clr", ccd_clr, 0);
        check("rel_lock", locked, 0);
        check("rel_done", done, 0);

        // 2: SAR to 9, start while busy ignored, clear width
        thr = 4'd9;
        track_en = 1'b0;
        clr_cnt = 0;
        start_pulse();
        for (int c = 1; c <= 86; c++) begin
            if (c == 1) check("t2_busy", busy, 1);
            if (c == 1) check("t2_w1", dly_code, 8);
            if (c == 22) check("t2_w2", dly_code, 12);
            if (c == 43) check("t2_w3", dly_code, 10);
            if (c == 64) check("t2_w4", dly_code, 9);
            if (c >= 22 && c <= 42 && ccd_clr) clr_cnt++;
            if (c == 42) check("t2_clr_w", clr_cnt, 2);
            if (c == 84) check("t2_pre", done, 0);
            if (c == 85) check("t2_done", done, 1);
            if (c == 85) check("t2_code", dly_code, 9);
            if (c == 86) check("t2_post", done, 0);
            if (c == 86) check("t2_idle", busy, 0);
            start = (c == 30);
            @(negedge clk);
        end

        // 3: rails
        run_sar(4'd15, 4'd15);
        run_sar(4'd0, 4'd0);

        // 4: tracking, lock, then saturation
        thr = 4'd9;
        track_en = 1'b1;
        start_pulse();
        for (int c = 1; c <= 338; c++) begin
            if (c == 85) check("t4_nodone", done, 0);
            if (c == 85) check("t4_sar", dly_code, 9);
            if (c == 106) check("t4_tr1", dly_code, 10);
            if (c == 127) check("t4_tr2", dly_code, 9);
            if (c == 148) check("t4_tr3", dly_code, 10);
            if (c == 169) check("t4_tr4", dly_code, 9);
            if (c == 169) check("t4_nolock", locked, 0);
            if (c == 190) check("t4_tr5", dly_code, 10);
            if (c == 190) check("t4_lock", locked, 1);
            if (c == 211) check("t4_up1", dly_code, 11);
            if (c == 211) check("t4_unlock", locked, 0);
            if (c == 337) check("t4_sat", dly_code, 15);
            if (c == 337) check("t4_satlk", locked, 0);
            if (c == 338) check("t4_ab_busy", busy, 0);
            if (c == 338) check("t4_ab_code", dly_code, 15);
            if (c == 190) force0 = 1'b1;
            abort = (c == 337);
            @(negedge clk);
        end
        force0 = 1'b0;
        track_en = 1'b0;

        // 5: abort in window 2 ACCUM, then restart
        thr = 4'd9;
        start_pulse();
        for (int c = 1; c <= 36; c++) begin
            if (c == 30) check("t5_accum", busy, 1);
            if (c == 31) check("t5_busy", busy, 0);
            if (c == 31) check("t5_clr", ccd_clr, 0);
            if (c == 31) check("t5_code", dly_code, 12);
            if (c == 31) check("t5_done", done, 0);
            if (c == 35) check("t5_restart", dly_code, 8);
            if (c == 35) check("t5_rclr", ccd_clr, 1);
            if (c == 35) check("t5_rbusy", busy, 1);
            abort = (c == 30) || (c == 35);
            start = (c == 34);
            @(negedge clk);
        end

        // 6: start together with abort
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("t6_busy", busy, 0);
        check("t6_clr", ccd_clr, 0);
        @(negedge clk);
        check("t6_busy2", busy, 0);

        // async reset mid-window
        thr = 4'd9;
        start_pulse();
        repeat (25) @(negedge clk);
        check("ar_pre", dly_code, 12);
        #2 rst = 1'b0;
        #1;
        check("ar_code", dly_code, 8);
        check("ar_busy", busy, 0);
        check("ar_clr", ccd_clr, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("ar_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
